// File: rtl/if_prefetch_pkg.sv
// Shared types and constants for the instruction-fetch prefetch stage.
package if_prefetch_pkg;

  localparam int          FETCH_BUF_DEPTH      = 4;
  localparam int          FETCH_BUF_DEPTH_LOG2 = 2;
  localparam logic [31:0] RESET_PC_DEF         = 32'h0000_0000;
  localparam logic [31:0] ZERO_WORD            = 32'h0000_0000;
  localparam logic        CHIP_ENABLE          = 1'b1;
  localparam logic        CHIP_DISABLE         = 1'b0;

  // Fetch sequencer: one dead cycle after reset, then fetch forever.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } fetch_state_e;

  // One queued fetch result.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  // Force a byte address onto a word boundary.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/if_fifo.sv
// Synchronous FIFO holding {pc, inst} pairs; clr empties it in one edge.
// Push and pop in the same cycle are legal at any fill level, including full:
// the slot being written is the one the head vacates.
module if_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  // Next-state for storage, pointers and fill count; clear wins over push/pop.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr) begin
      wr_ptr_d = {AW{1'b0}};
      rd_ptr_d = {AW{1'b0}};
      count_d  = {CW{1'b0}};
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = din;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Head entry straight from storage; zero when empty.
  always_comb begin
    if (count_q != {CW{1'b0}}) begin
      dout = mem_q[rd_ptr_q];
    end else begin
      dout = {WIDTH{1'b0}};
    end
  end

  assign count = count_q;

endmodule

// File: rtl/if_prefetch.sv
// Instruction-fetch stage: drives the combinational ROM and buffers fetched
// words in a small queue so ID stalls never drop an instruction.
module if_prefetch
  import if_prefetch_pkg::*;
#(
  parameter int          DEPTH    = FETCH_BUF_DEPTH,
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  input  logic        id_ready,
  output logic        rom_ce,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_inst,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e  state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic          run_s;
  logic          push_s;
  logic          pop_s;
  logic [CW-1:0] count_s;
  fetch_entry_t  tail_s;
  fetch_entry_t  head_s;
  logic [63:0]   fifo_dout_s;

  // Sequencer, fetch-address update and push/pop arbitration (flush beats push/pop).
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    run_s      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        run_s   = 1'b0;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        run_s   = 1'b1;
        state_d = ST_RUN;
      end
      default: begin
        run_s   = 1'b0;
        state_d = ST_IDLE;
      end
    endcase

    pop_s  = (count_s != {CW{1'b0}}) & id_ready & ~flush;
    push_s = run_s & ~flush & ((count_s < CW'(DEPTH)) | pop_s);

    if (flush) begin
      fetch_pc_d = align_word(flush_pc);
    end else if (push_s) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
    end else begin
      fetch_pc_d = fetch_pc_q;
    end
  end

  // Sequencer state and fetch address registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      fetch_pc_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
    end
  end

  assign tail_s.pc   = fetch_pc_q;
  assign tail_s.inst = rom_inst;

  if_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (64)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (flush),
    .push  (push_s),
    .pop   (pop_s),
    .din   (tail_s),
    .dout  (fifo_dout_s),
    .count (count_s)
  );

  assign head_s = fifo_dout_s;

  // Output drive: ROM interface from the sequencer, ID interface from the queue head.
  always_comb begin
    if (run_s) begin
      rom_ce = CHIP_ENABLE;
    end else begin
      rom_ce = CHIP_DISABLE;
    end
    rom_addr = fetch_pc_q;
    if_valid = (count_s != {CW{1'b0}});
    if_pc    = head_s.pc;
    if_inst  = head_s.inst;
  end

endmodule
